// File: rtl/kp_midi_pkg.sv
// Shared MIDI constants, 48 kHz period table and FSM state type for the
// Karplus-Strong voice allocator.
package kp_midi_pkg;

  localparam logic [3:0]  NOTE_OFF    = 4'h8;
  localparam logic [3:0]  NOTE_ON     = 4'h9;
  localparam logic [3:0]  BEND        = 4'hE;
  localparam logic [13:0] BEND_CENTRE = 14'd8192;

  // Periods in 48 kHz samples for MIDI notes 0..11; higher octaves are right shifts.
  localparam logic [15:0] BASE_PERIOD [0:11] = '{
    16'd5871, 16'd5541, 16'd5230, 16'd4937, 16'd4660, 16'd4398,
    16'd4151, 16'd3918, 16'd3698, 16'd3491, 16'd3295, 16'd3110
  };

  typedef enum logic [1:0] {IDLE, DECODE, COMMIT, SWEEP} kp_state_e;

endpackage

// File: rtl/kp_voice_allocator_if.sv
// Parsed MIDI message channel with valid/ready handshake.
interface kp_voice_allocator_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;

  modport master (output msg_valid, msg_status, msg_data1, msg_data2, input msg_ready);
  modport slave  (input msg_valid, msg_status, msg_data1, msg_data2, output msg_ready);
endinterface

// File: rtl/kp_note_to_delay.sv
// Combinational MIDI note (+ optional pitch bend) to saturated delay length.
// Bend term is present only when KP_PITCH_BEND_EN is defined.
module kp_note_to_delay
  import kp_midi_pkg::*;
#(
  parameter int DELAY_W = 10
) (
  input  logic [6:0]         note,
  input  logic [13:0]        bend,
  output logic [DELAY_W-1:0] delay
);

  localparam int D_MAX = 2**DELAY_W - 1;

  logic [3:0]         pc;
  logic [3:0]         oct;
  logic [15:0]        d;
  logic signed [31:0] d_s;
  logic signed [31:0] d_bent;

`ifdef KP_PITCH_BEND_EN
  logic signed [31:0] bend_off;
  logic signed [31:0] prod;
`else
  logic unused_bend;
  assign unused_bend = ^bend;
`endif

  always_comb begin
    pc     = 4'(note % 7'd12);
    oct    = 4'(note / 7'd12);
    d      = BASE_PERIOD[pc] >> oct;
    d_s    = 32'(d);
`ifdef KP_PITCH_BEND_EN
    bend_off = 32'(bend) - 32'(BEND_CENTRE);
    prod     = d_s * bend_off;
    // Arithmetic shift keeps the sign so bend below centre lengthens the period.
    d_bent   = d_s - (prod >>> 16);
`else
    d_bent   = d_s;
`endif
    if (d_bent < 2)
      delay = DELAY_W'(2);
    else if (d_bent > D_MAX)
      delay = DELAY_W'(D_MAX);
    else
      delay = d_bent[DELAY_W-1:0];
  end

endmodule

// File: rtl/kp_voice_allocator.sv
// Polyphonic MIDI front end: channel filter, voice allocation with round-robin
// stealing, per-voice delay/decay/pluck. Pitch bend gated by KP_PITCH_BEND_EN.
//
// state  | meaning
// IDLE   | msg_ready high, waiting for a message
// DECODE | message latched, classify opcode/channel
// COMMIT | apply note-on / note-off to the chosen voice
// SWEEP  | recompute delay of one voice per cycle after a bend
module kp_voice_allocator
  import kp_midi_pkg::*;
#(
  parameter int                 NUM_VOICES    = 4,
  parameter int                 DELAY_W       = 10,
  parameter int                 DECAY_W       = 12,
  parameter int                 CHANNEL       = 0,
  parameter logic [DECAY_W-1:0] RELEASE_DECAY = 12'h200
) (
  input  logic                          clk,
  input  logic                          reset_n,
  kp_voice_allocator_if.slave           msg,
  output logic [NUM_VOICES*DELAY_W-1:0] voice_delay,
  output logic [NUM_VOICES*DECAY_W-1:0] voice_decay,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [NUM_VOICES-1:0]         voice_pluck,
  output logic                          steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  kp_state_e        state, next_state;
  logic             ready;
  logic [3:0]       op_q;
  logic [3:0]       ch_q;
  logic [6:0]       d1_q;
  logic [6:0]       d2_q;
  logic [6:0]       voice_note [NUM_VOICES];
  logic [IDX_W-1:0] steal_ptr;
  logic             ch_match;
  logic             is_on;
  logic             hit;
  logic             free;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel;
  logic [6:0]       n2d_note;
  logic [13:0]      n2d_bend;
  logic [DELAY_W-1:0] new_delay;

`ifdef KP_PITCH_BEND_EN
  logic [13:0]      bend_q;
  logic [IDX_W-1:0] sweep_idx;
  assign n2d_note = (state == SWEEP) ? voice_note[sweep_idx] : d1_q;
  assign n2d_bend = bend_q;
`else
  assign n2d_note = d1_q;
  assign n2d_bend = BEND_CENTRE;
`endif

  assign msg.msg_ready = ready;
  assign ch_match      = (ch_q == 4'(CHANNEL));
  assign is_on         = (op_q == NOTE_ON) && (d2_q != 7'd0);

  kp_note_to_delay #(.DELAY_W(DELAY_W)) u_n2d (
    .note  (n2d_note),
    .bend  (n2d_bend),
    .delay (new_delay)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (msg.msg_valid) next_state = DECODE;
      end
      DECODE: begin
        next_state = IDLE;
        if (ch_match) begin
          if (op_q == NOTE_ON || op_q == NOTE_OFF) next_state = COMMIT;
`ifdef KP_PITCH_BEND_EN
          else if (op_q == BEND) next_state = SWEEP;
`endif
        end
      end
      COMMIT: next_state = IDLE;
`ifdef KP_PITCH_BEND_EN
      SWEEP: if (sweep_idx == LAST_IDX) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Descending scan so the lowest-index candidate wins.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_active[i] && voice_note[i] == d1_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!voice_active[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    sel = steal_ptr;
    if (hit)       sel = hit_idx;
    else if (free) sel = free_idx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q         <= '0;
      ch_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      steal_ptr    <= '0;
      voice_delay  <= '0;
      voice_decay  <= '0;
      voice_active <= '0;
      voice_pluck  <= '0;
      steal        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) voice_note[i] <= '0;
`ifdef KP_PITCH_BEND_EN
      bend_q       <= BEND_CENTRE;
      sweep_idx    <= '0;
`endif
    end else begin
      voice_pluck <= '0;
      steal       <= 1'b0;
      if (state == IDLE && msg.msg_valid) begin
        op_q <= msg.msg_status[7:4];
        ch_q <= msg.msg_status[3:0];
        d1_q <= msg.msg_data1;
        d2_q <= msg.msg_data2;
      end
`ifdef KP_PITCH_BEND_EN
      if (state == DECODE) begin
        sweep_idx <= '0;
        if (ch_match && op_q == BEND) bend_q <= {d2_q, d1_q};
      end
      if (state == SWEEP) begin
        voice_delay[sweep_idx*DELAY_W +: DELAY_W] <= new_delay;
        sweep_idx <= sweep_idx + IDX_W'(1);
      end
`endif
      if (state == COMMIT) begin
        if (is_on) begin
          voice_active[sel]                   <= 1'b1;
          voice_note[sel]                     <= d1_q;
          voice_delay[sel*DELAY_W +: DELAY_W] <= new_delay;
          voice_decay[sel*DECAY_W +: DECAY_W] <= {d2_q, {(DECAY_W-7){1'b1}}};
          voice_pluck[sel]                    <= 1'b1;
          if (!hit && !free) begin
            steal     <= 1'b1;
            steal_ptr <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + IDX_W'(1);
          end
        end else if (hit) begin
          voice_active[hit_idx]                   <= 1'b0;
          voice_decay[hit_idx*DECAY_W +: DECAY_W] <= RELEASE_DECAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_kp_voice_allocator.sv
// Directed self-checking bench for kp_voice_allocator (default parameters);
// bend expectations follow KP_PITCH_BEND_EN.
module tb_kp_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [39:0] voice_delay;
  logic [47:0] voice_decay;
  logic [3:0]  voice_active;
  logic [3:0]  voice_pluck;
  logic        steal;
  int          checks = 0;
  int          failures = 0;
  int          cnt;

  kp_voice_allocator_if m();

  kp_voice_allocator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .msg          (m),
    .voice_delay  (voice_delay),
    .voice_decay  (voice_decay),
    .voice_active (voice_active),
    .voice_pluck  (voice_pluck),
    .steal        (steal)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dly(input int i);
    return voice_delay[i*10 +: 10];
  endfunction

  function automatic logic [11:0] dcy(input int i);
    return voice_decay[i*12 +: 12];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns one tick after the transfer edge, with msg_valid dropped.
  task automatic send(input logic [7:0] st, input logic [6:0] a, input logic [6:0] b);
    int n;
    n = 0;
    m.msg_valid = 1'b1;
    m.msg_status = st;
    m.msg_data1 = a;
    m.msg_data2 = b;
    while (m.msg_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", m.msg_ready, 1);
    @(posedge clk); #1;
    m.msg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (m.msg_ready !== 1'b1 && c < 50) begin
      c++;
      @(posedge clk); #1;
    end
    check("ready_return", m.msg_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m.msg_valid = 1'b0;
    m.msg_status = '0;
    m.msg_data1 = '0;
    m.msg_data2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_delay", voice_delay, 0);
    check("rst_decay", voice_decay, 0);
    check("rst_active", voice_active, 0);
    check("rst_pluck", voice_pluck, 0);
    check("rst_steal", steal, 0);
    check("rst_ready", m.msg_ready, 1);
    reset_n = 1'b1;

    // Note-on 69 vel 127: outputs land at E2, ready back after E2.
    send(8'h90, 7'd69, 7'd127);
    check("n69_ready_e0", m.msg_ready, 0);
    @(posedge clk); #1;
    check("n69_ready_e1", m.msg_ready, 0);
    check("n69_pluck_e1", voice_pluck, 0);
    check("n69_active_e1", voice_active, 0);
    @(posedge clk); #1;
    check("n69_ready_e2", m.msg_ready, 1);
    check("n69_pluck_e2", voice_pluck, 4'b0001);
    check("n69_delay", dly(0), 109);
    check("n69_decay", dcy(0), 12'hFFF);
    check("n69_active", voice_active, 4'b0001);
    @(posedge clk); #1;
    check("n69_pluck_off", voice_pluck, 0);

    // Full-up bend, then back to centre.
    send(8'hE0, 7'h7F, 7'h7F);
    wait_ready(cnt);
`ifdef KP_PITCH_BEND_EN
    check("bend_ready_low", cnt, 5);
    check("bend_delay0", dly(0), 96);
`else
    check("bend_ready_low", cnt, 1);
    check("bend_delay0", dly(0), 109);
`endif
    check("bend_pluck", voice_pluck, 0);
    check("bend_active", voice_active, 4'b0001);
    send(8'hE0, 7'h00, 7'h40);
    wait_ready(cnt);
    check("bend_centre_delay0", dly(0), 109);

    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Back-to-back note-ons fill all four voices.
    send(8'h90, 7'd60, 7'd100);
    send(8'h90, 7'd62, 7'd100);
    send(8'h90, 7'd64, 7'd100);
    send(8'h90, 7'd65, 7'd100);
    wait_ready(cnt);
    check("fill_delay", voice_delay, {10'd137, 10'd145, 10'd163, 10'd183});
    check("fill_decay", voice_decay, {12'hC9F, 12'hC9F, 12'hC9F, 12'hC9F});
    check("fill_active", voice_active, 4'b1111);

    send(8'h90, 7'd67, 7'd64);
    wait_ready(cnt);
    check("steal0_pulse", steal, 1);
    check("steal0_pluck", voice_pluck, 4'b0001);
    check("steal0_delay", dly(0), 122);
    check("steal0_decay", dcy(0), 12'h81F);
    @(posedge clk); #1;
    check("steal0_pulse_off", steal, 0);

    send(8'h90, 7'd71, 7'd64);
    wait_ready(cnt);
    check("steal1_pulse", steal, 1);
    check("steal1_pluck", voice_pluck, 4'b0010);
    check("steal1_delay", dly(1), 97);

    // Retrigger of an already-held note.
    send(8'h90, 7'd64, 7'd10);
    wait_ready(cnt);
    check("retrig_steal", steal, 0);
    check("retrig_pluck", voice_pluck, 4'b0100);
    check("retrig_decay", dcy(2), 12'h15F);
    check("retrig_active", voice_active, 4'b1111);

    send(8'h80, 7'd64, 7'd0);
    wait_ready(cnt);
    check("off_active", voice_active, 4'b1011);
    check("off_decay", dcy(2), 12'h200);
    check("off_delay_kept", dly(2), 145);
    check("off_pluck", voice_pluck, 0);

    send(8'h80, 7'd64, 7'd0);
    wait_ready(cnt);
    check("off2_active", voice_active, 4'b1011);
    check("off2_delay", voice_delay, {10'd137, 10'd145, 10'd97, 10'd122});
    check("off2_decay", voice_decay, {12'hC9F, 12'h200, 12'h81F, 12'h81F});

    send(8'h93, 7'd50, 7'd100);
    wait_ready(cnt);
    check("chan_ready_low", cnt, 1);
    check("chan_active", voice_active, 4'b1011);
    check("chan_delay", voice_delay, {10'd137, 10'd145, 10'd97, 10'd122});
    check("chan_pluck", voice_pluck, 0);

    send(8'h90, 7'd65, 7'd0);
    wait_ready(cnt);
    check("vel0_active", voice_active, 4'b0011);
    check("vel0_decay", dcy(3), 12'h200);
    check("vel0_pluck", voice_pluck, 0);

    send(8'h90, 7'd0, 7'd127);
    wait_ready(cnt);
    check("note0_pluck", voice_pluck, 4'b0100);
    check("note0_delay", dly(2), 1023);
    send(8'h90, 7'd127, 7'd127);
    wait_ready(cnt);
    check("note127_delay", dly(3), 3);
    check("note127_active", voice_active, 4'b1111);

    send(8'hB0, 7'd1, 7'd1);
    wait_ready(cnt);
    check("ignored_ready_low", cnt, 1);
    check("ignored_delay", voice_delay, {10'd3, 10'd1023, 10'd97, 10'd122});

    // Reset asserted while the note-on is in COMMIT.
    send(8'h90, 7'd60, 7'd100);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_pluck", voice_pluck, 0);
    check("abort_steal", steal, 0);
    check("abort_delay", voice_delay, 0);
    check("abort_decay", voice_decay, 0);
    check("abort_active", voice_active, 0);
    check("abort_ready", m.msg_ready, 1);
    reset_n = 1'b1;

    send(8'h90, 7'd69, 7'd127);
    wait_ready(cnt);
    check("post_abort_delay", dly(0), 109);
    check("post_abort_pluck", voice_pluck, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
